// File: rtl/uart_ram_loader.sv
// Frame-based UART bootloader: collects header/length/data/checksum bytes, writes 32-bit words
// into RAM port A and answers with a single ACK/NAK byte once the frame ends.
module uart_ram_loader #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_LEN       = 14,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  sw_uart_upgrade_b,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  output logic                  uart_tx_valid,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_busy,
  output logic                  during_sw_upgrade,
  output logic                  ram_wr_en,
  output logic [ADDR_LEN-1:0]   ram_addr,
  output logic [XLEN-1:0]       ram_wr_data,
  output logic [XLEN/8-1:0]     ram_we
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned BcW      = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]          Header   = 8'hA5;
  localparam logic [7:0]          Ack      = 8'h06;
  localparam logic [7:0]          Nak      = 8'h15;
  localparam logic [TmoW-1:0]     TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [BcW-1:0]      LastByte = BcW'(NumBytes - 1);
  localparam logic [ADDR_LEN-1:0] BaseAddr = ADDR_LEN'(BASE_ADDR);

  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StCsum, StResp} state_e;

  state_e state_q, state_d;

  logic                en_meta_q, en_sync_q;
  logic [15:0]         len_q, len_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [BcW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [XLEN-1:0]     word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          resp_q, resp_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                during_q, during_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   we_q, we_d;
  logic                in_frame;
  logic                abort;
  logic                tx_valid;
  logic [7:0]          tx_data;

  // Synchroniser resets to "disabled" so no frame is accepted until the input has settled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_meta_q <= 1'b1;
      en_sync_q <= 1'b1;
    end else begin
      en_meta_q <= sw_uart_upgrade_b;
      en_sync_q <= en_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      resp_q     <= '0;
      tmo_cnt_q  <= '0;
      during_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
    end else begin
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      resp_q     <= resp_d;
      tmo_cnt_q  <= tmo_cnt_d;
      during_q   <= during_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  assign in_frame = (state_q == StLen0) || (state_q == StLen1) ||
                    (state_q == StData) || (state_q == StCsum);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    resp_d     = resp_q;
    tmo_cnt_d  = tmo_cnt_q;
    during_d   = during_q;
    wr_en_d    = 1'b0;
    we_d       = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_valid   = 1'b0;
    tx_data    = '0;
    abort      = 1'b0;

    if (in_frame) begin
      tmo_cnt_d = uart_rx_valid ? '0 : tmo_cnt_q + 1'b1;
      // A withdrawn enable is handled exactly like an inter-byte timeout.
      abort     = en_sync_q || (!uart_rx_valid && (tmo_cnt_q == TmoLast));
    end

    if (abort) begin
      resp_d    = Nak;
      tmo_cnt_d = '0;
      state_d   = StResp;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (uart_rx_valid && !en_sync_q && (uart_rx_data == Header)) begin
            state_d    = StLen0;
            during_d   = 1'b1;
            csum_d     = '0;
            word_idx_d = '0;
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
          end
        end
        StLen0: begin
          if (uart_rx_valid) begin
            len_d[7:0] = uart_rx_data;
            state_d    = StLen1;
          end
        end
        StLen1: begin
          if (uart_rx_valid) begin
            len_d[15:8] = uart_rx_data;
            state_d     = ({uart_rx_data, len_q[7:0]} == 16'd0) ? StCsum : StData;
          end
        end
        StData: begin
          if (uart_rx_valid) begin
            word_d[8*byte_cnt_q +: 8] = uart_rx_data;
            csum_d     = csum_q + uart_rx_data;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == LastByte) begin
              byte_cnt_d = '0;
              wr_en_d    = 1'b1;
              we_d       = '1;
              addr_d     = BaseAddr + ADDR_LEN'(word_idx_q);
              wdata_d    = word_d;
              word_idx_d = word_idx_q + 16'd1;
              if (word_idx_q == len_q - 16'd1) begin
                state_d = StCsum;
              end
            end
          end
        end
        StCsum: begin
          if (uart_rx_valid) begin
            resp_d  = (uart_rx_data == csum_q) ? Ack : Nak;
            state_d = StResp;
          end
        end
        StResp: begin
          if (!uart_tx_busy) begin
            tx_valid = 1'b1;
            tx_data  = resp_q;
            during_d = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign uart_tx_valid     = tx_valid;
  assign uart_tx_data      = tx_data;
  assign during_sw_upgrade = during_q;
  assign ram_wr_en         = wr_en_q;
  assign ram_addr          = addr_q;
  assign ram_wr_data       = wdata_q;
  assign ram_we            = we_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomised scoreboard bench for uart_ram_loader: two instances (base address 0 and 16383)
// share the stimulus; a frame-level model predicts RAM writes and the response byte.
module tb_uart_ram_loader;

  localparam int unsigned Tmo = 100;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en_b = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic busy = 1'b0;

  logic        tx_valid0, tx_valid1, during0, during1, wr0, wr1;
  logic [7:0]  tx_data0, tx_data1;
  logic [13:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  we0, we1;

  uart_ram_loader #(.XLEN(32), .ADDR_LEN(14), .BASE_ADDR(0), .TIMEOUT_CYCLES(Tmo)) dut0 (
    .clk(clk), .rstb(rstb), .sw_uart_upgrade_b(en_b), .uart_rx_valid(rx_valid),
    .uart_rx_data(rx_data), .uart_tx_valid(tx_valid0), .uart_tx_data(tx_data0),
    .uart_tx_busy(busy), .during_sw_upgrade(during0), .ram_wr_en(wr0), .ram_addr(addr0),
    .ram_wr_data(wdata0), .ram_we(we0)
  );

  uart_ram_loader #(.XLEN(32), .ADDR_LEN(14), .BASE_ADDR(16383), .TIMEOUT_CYCLES(Tmo)) dut1 (
    .clk(clk), .rstb(rstb), .sw_uart_upgrade_b(en_b), .uart_rx_valid(rx_valid),
    .uart_rx_data(rx_data), .uart_tx_valid(tx_valid1), .uart_tx_data(tx_data1),
    .uart_tx_busy(busy), .during_sw_upgrade(during1), .ram_wr_en(wr1), .ram_addr(addr1),
    .ram_wr_data(wdata1), .ram_we(we1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [45:0] exp_ram0[$];
  logic [45:0] exp_ram1[$];
  logic [7:0]  exp_tx0[$];
  logic [7:0]  exp_tx1[$];
  logic [45:0] e0, e1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever either instance presents a write or a tx strobe.
  always @(negedge clk) begin
    if (rstb) begin
      if (wr0) begin
        if (exp_ram0.size() == 0) check("ram0_unexpected", 1, 0);
        else begin
          e0 = exp_ram0.pop_front();
          check("ram0_addr_data", {addr0, wdata0}, e0);
          check("ram0_we", we0, 4'hF);
        end
      end
      if (wr1) begin
        if (exp_ram1.size() == 0) check("ram1_unexpected", 1, 0);
        else begin
          e1 = exp_ram1.pop_front();
          check("ram1_addr_data", {addr1, wdata1}, e1);
          check("ram1_we", we1, 4'hF);
        end
      end
      if (tx_valid0) begin
        check("tx0_while_busy", busy, 0);
        check("tx0_during_high", during0, 1);
        if (exp_tx0.size() == 0) check("tx0_unexpected", 1, 0);
        else check("tx0_byte", tx_data0, exp_tx0.pop_front());
      end
      if (tx_valid1) begin
        if (exp_tx1.size() == 0) check("tx1_unexpected", 1, 0);
        else check("tx1_byte", tx_data1, exp_tx1.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int c = 0; c < 300 && exp_tx0.size() != 0; c++) idle(1);
    check("resp_seen", exp_tx0.size(), 0);
    exp_tx0.delete();
    exp_tx1.delete();
    idle(1);
    check("during_cleared", during0, 0);
    check("ram_all_written", exp_ram0.size() + exp_ram1.size(), 0);
    exp_ram0.delete();
    exp_ram1.delete();
  endtask

  // mode 0: full frame; 1: truncated then silence; 2: truncated then enable withdrawn.
  task automatic run_frame(input int n, input int mode, input bit fixed, input bit bad,
                           input bit busy_end, input int cut);
    logic [7:0] body[$];
    logic [7:0] b;
    logic [7:0] sum;
    logic [31:0] w;
    int sent;
    body.push_back(n[7:0]);
    body.push_back(n[15:8]);
    sum = 8'h00;
    for (int k = 0; k < 4 * n; k++) begin
      b = fixed ? 8'((k + 1) * 17) : 8'($urandom);
      body.push_back(b);
      sum = sum + b;
    end
    body.push_back(bad ? sum + 8'd1 : sum);
    if (mode == 0) sent = body.size();
    else if (cut >= 0) sent = cut;
    else sent = 2 + $urandom_range(0, 4 * n);
    for (int i = 0; i < n; i++) begin
      if (2 + 4 * i + 3 < sent) begin
        w = {body[2+4*i+3], body[2+4*i+2], body[2+4*i+1], body[2+4*i]};
        exp_ram0.push_back({14'(i % 16384), w});
        exp_ram1.push_back({14'((16383 + i) % 16384), w});
      end
    end
    b = (mode == 0 && !bad) ? 8'h06 : 8'h15;
    exp_tx0.push_back(b);
    exp_tx1.push_back(b);

    send_byte(8'hA5);
    check("during_after_hdr", during0, 1);
    for (int k = 0; k < sent; k++) begin
      if (busy_end && k == sent - 1) busy = 1'b1;
      send_byte(body[k]);
      if (k < sent - 1) idle($urandom_range(0, 3));
    end
    if (mode == 2) en_b = 1'b1;
    if (busy_end) begin
      idle(50);
      check("tx_held_while_busy", exp_tx0.size(), 1);
      busy = 1'b0;
      @(negedge clk);
      check("tx_first_cycle_idle", tx_valid0, 1);
    end
    wait_resp();
    if (mode == 2) begin
      en_b = 1'b0;
      idle(3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int mode;
    idle(3);
    check("rst_outputs", {tx_valid0, tx_data0, during0, wr0, addr0, wdata0, we0}, 0);
    rstb = 1'b1;
    en_b = 1'b0;
    idle(3);

    run_frame(2, 0, 1'b1, 1'b0, 1'b0, -1);
    run_frame(2, 0, 1'b1, 1'b1, 1'b0, -1);
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, -1);

    en_b = 1'b1;
    idle(3);
    for (int k = 0; k < 6; k++) begin
      send_byte((k == 0) ? 8'hA5 : (k == 1) ? 8'h01 : 8'h00);
      check("disabled_no_frame", during0, 0);
    end
    idle(20);
    en_b = 1'b0;
    idle(3);

    run_frame(1, 1, 1'b1, 1'b0, 1'b0, 4);
    run_frame(2, 0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(2, 2, 1'b0, 1'b0, 1'b0, 7);

    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    rstb = 1'b0;
    idle(2);
    check("mid_rst_outputs", {tx_valid0, during0, wr0, we0}, 0);
    rstb = 1'b1;
    idle(20);
    check("post_rst_idle", during0, 0);

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 4);
      mode = (n == 0) ? 0 : $urandom_range(0, 2);
      run_frame(n, mode, 1'b0, ($urandom_range(0, 2) == 0), (mode == 0) &&
                ($urandom_range(0, 3) == 0), -1);
    end

    idle(5);
    check("scoreboard_empty", exp_ram0.size() + exp_ram1.size() + exp_tx0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
